dmem_responder: RTL and testbench

Data-memory responder for the MIPS core's load/store port. It serves the other end of the core's memwrite/dataadr/writedata/readdata interface, but with a valid/ready request–response handshake and a programmable wait-state count instead of a zero-latency combinational read. It replaces the plain data memory when the core is built with stall support, and is the model for slower backing memories.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_ram_array.sv | 23 ++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// Optional perf counters: DMEM_RESPONDER_PERF_CNT_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;
  localparam int PERF_W = 16;

endpackage

// File: rtl/dmem_ram_array.sv
// Word storage for dmem_responder: synchronous write, async read.
// No reset; contents survive a responder reset.
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with programmable wait states.
// Optional rd_cnt/wr_cnt outputs: DMEM_RESPONDER_PERF_CNT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
`ifdef DMEM_RESPONDER_PERF_CNT_EN
  output logic [PERF_W-1:0] rd_cnt,
  output logic [PERF_W-1:0] wr_cnt,
`endif
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_LD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cap;
  logic              we_q, mis_q;
  logic [ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic              mem_we;
  logic [WORD_W-1:0] ram_rdata;

  // Upper address bits alias silently.
  logic unused_addr;
  assign unused_addr = ^req_addr[WORD_W-1:ADDR_W+2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap       = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cap = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else cnt_d = cnt_q - 1'b1;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = (state_q == ACCESS) && we_q && !mis_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        we_q    <= req_we;
        mis_q   <= (req_addr[1:0] != 2'b00);
        idx_q   <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (we_q || mis_q) ? '0 : ram_rdata;
        err_q   <= mis_q;
      end
    end
  end

`ifdef DMEM_RESPONDER_PERF_CNT_EN
  logic acc_ok;
  assign acc_ok = (state_q == ACCESS) && !mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (acc_ok && !we_q && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (acc_ok && we_q && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
    end
  end
`endif

  dmem_ram_array #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Build with DMEM_RESPONDER_PERF_CNT_EN to use WAIT_CYCLES=0 and counters.
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_PERF_CNT_EN
  localparam int WC = 0;
`else
  localparam int WC = 2;
`endif
  localparam int LAT = WC + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
`ifdef DMEM_RESPONDER_PERF_CNT_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
`ifdef DMEM_RESPONDER_PERF_CNT_EN
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
`endif
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with rsp_ready=1; lat counts edges from acceptance.
  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic er, output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: valid=%b err=%b rdata=%h busy=%b rdy=%b",
               rsp_valid, rsp_err, rsp_rdata, busy, req_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    tests++;
    if (lat !== LAT || rd !== 32'h0 || er !== 1'b0) begin
      fails++;
      $display("FAIL store: lat=%0d rd=%h err=%b exp lat=%0d rd=0 err=0",
               lat, rd, er, LAT);
    end
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    tests++;
    if (lat !== LAT || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL load: lat=%0d rd=%h err=%b exp lat=%0d rd=deadbeef",
               lat, rd, er, LAT);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b0, 32'h13, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++;
      $display("FAIL misload: rd=%h err=%b exp rd=0 err=1", rd, er);
    end
    txn(1'b1, 32'h12, 32'hCAFEF00D, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++;
      $display("FAIL misstore: rd=%h err=%b exp rd=0 err=1", rd, er);
    end
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL misclean: rd=%h err=%b exp deadbeef/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL bp_lat: lat=%0d exp %0d", lat, LAT);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF ||
          req_ready !== 1'b0) bad++;
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d bad cycles exp 0", bad);
    end
    rsp_ready = 1'b1;
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: valid=%b rdy=%b busy=%b exp 0/1/0",
               rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, 32'h104, 32'h12345678, rd, er, lat);
    txn(1'b0, 32'h004, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      fails++;
      $display("FAIL alias: rd=%h err=%b exp 12345678/0", rd, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, 32'h20, 32'h11111111, rd, er, lat);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rstmid: valid=%b busy=%b err=%b rd=%h exp 0",
               rsp_valid, busy, rsp_err, rsp_rdata);
    end
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h11111111) begin
      fails++;
      $display("FAIL rstmid_data: rd=%h exp 11111111", rd);
    end
  endtask

`ifdef DMEM_RESPONDER_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] rd;
    logic er;
    int lat;
    int badlat;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    tests++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      fails++;
      $display("FAIL perf_rst: rd=%0d wr=%0d exp 0/0", rd_cnt, wr_cnt);
    end
    badlat = 0;
    txn(1'b1, 32'h30, 32'h1, rd, er, lat); if (lat != 2) badlat++;
    txn(1'b1, 32'h34, 32'h2, rd, er, lat); if (lat != 2) badlat++;
    txn(1'b1, 32'h38, 32'h3, rd, er, lat); if (lat != 2) badlat++;
    txn(1'b0, 32'h34, 32'h0, rd, er, lat); if (lat != 2) badlat++;
    tests++;
    if (rd !== 32'h2) begin
      fails++;
      $display("FAIL perf_load: rd=%h exp 2", rd);
    end
    txn(1'b0, 32'h38, 32'h0, rd, er, lat); if (lat != 2) badlat++;
    txn(1'b0, 32'h31, 32'h0, rd, er, lat); if (lat != 2) badlat++;
    tests++;
    if (badlat != 0) begin
      fails++;
      $display("FAIL perf_lat: %0d txns not 2 cycles", badlat);
    end
    tests++;
    if (wr_cnt !== 16'd3 || rd_cnt !== 16'd2) begin
      fails++;
      $display("FAIL perf_cnt: wr=%0d rd=%0d exp 3/2", wr_cnt, rd_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_backpressure();
    test_alias();
    test_reset_mid();
`ifdef DMEM_RESPONDER_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
